// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; one bit minimum so WIDTH = 1 still has a counter.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// One-bit full adder: the only arithmetic in the serial adder.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through a
// single full-adder cell with a registered carry loop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;

    fa_bit_cell u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // Result register shifts right, new sum bit enters at the MSB
    // (written this way so WIDTH = 1 needs no special slice).
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_s;
    end

    // Control FSM plus all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Result held untouched until the consumer takes it.
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // All outputs come straight from state or registers.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_res;
    assign cout      = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a result scoreboard queue.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected {cout, sum} per accepted operation.
    logic [W:0] sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Compare current output against the head of the scoreboard (no pop).
    task automatic check_head(input string tag);
        logic [W:0] exp;
        exp = (sb.size() != 0) ? sb[0] : {(W+1){1'bx}};
        chk(tag, {23'd0, cout, sum}, {23'd0, exp});
    endtask

    // Offer operands; returns just after the accept edge.
    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
        int n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        a = x; b = y; cin = c; in_valid = 1'b1;
        if (push) sb.push_back(ref_add(x, y, c));
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Consume result for one cycle and confirm return to IDLE.
    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int highs;
        int acc[2];
        int nacc;
        int nout;
        logic [W-1:0] ba[2];
        logic [W-1:0] bb[2];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);

        // Basic add with latency check
        start(8'h12, 8'h34, 1'b0, 1'b1);
        wait_valid(n);
        chk("basic_latency", n, W);
        chk("basic_const", {23'd0, cout, sum}, 32'h046);
        check_head("basic_sb");
        release_out();

        // Full carry ripple
        start(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_valid(n);
        chk("ripple1", {23'd0, cout, sum}, 32'h100);
        check_head("ripple1_sb");
        release_out();

        start(8'hA5, 8'h5A, 1'b1, 1'b1);
        wait_valid(n);
        chk("ripple2", {23'd0, cout, sum}, 32'h100);
        check_head("ripple2_sb");
        release_out();

        // Back-pressure: result must hold for 5 stalled cycles
        start(8'h80, 8'h80, 1'b0, 1'b1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check_head("bp_hold");
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        check_head("bp_final");
        release_out();

        // in_valid during RUN must be ignored
        start(8'h01, 8'h01, 1'b0, 1'b1);
        tick(); tick();
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ign_in_ready", {31'd0, in_ready}, 32'd0);
        wait_valid(n);
        chk("ign_result", {23'd0, cout, sum}, 32'h002);
        check_head("ign_sb");
        release_out();
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) highs++;
            tick();
        end
        chk("ign_no_second", highs, 0);

        // Reset during RUN bit 3 aborts the operation
        start(8'h55, 8'h66, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {24'd0, sum}, 32'd0);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) highs++;
            tick();
        end
        chk("midrst_no_output", highs, 0);
        start(8'h03, 8'h04, 1'b0, 1'b1);
        wait_valid(n);
        chk("post_rst", {23'd0, cout, sum}, 32'h007);
        check_head("post_rst_sb");
        release_out();

        // Back-to-back with out_ready tied high
        ba[0] = 8'hC3; bb[0] = 8'h7E;
        ba[1] = 8'h0F; bb[1] = 8'hF1;
        out_ready = 1'b1;
        nacc = 0; nout = 0;
        acc[0] = 0; acc[1] = 0;
        for (int i = 0; i < 60 && nout < 2; i++) begin
            if (out_valid) begin
                check_head("b2b_result");
                if (sb.size() != 0) void'(sb.pop_front());
                nout++;
            end
            if (in_ready && nacc < 2) begin
                a = ba[nacc]; b = bb[nacc]; cin = 1'b0; in_valid = 1'b1;
                sb.push_back(ref_add(ba[nacc], bb[nacc], 1'b0));
                acc[nacc] = cyc + 1;
                nacc++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_outputs", nout, 2);
        chk("b2b_spacing", acc[1] - acc[0], W + 2);

        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single one-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake, then processes one bit per clock, LSB first, feeding the cell's carry-out back through a carry register. It presents the WIDTH-bit sum and final carry-out on a valid/ready output port. It sits directly around the full-adder cell: it feeds the cell its operand bits each cycle and consumes its sum/carry outputs. This trades latency for area against a ripple or parallel adder.

## Interface
- WIDTH, 8, operand/sum width in bits; legal for WIDTH ≥ 1.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum and cout hold a completed result.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  bit WIDTH of a + b + cin.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid & in_ready, load a and b into shift registers and cin into the carry register, clear the bit counter, and go to RUN.
- RUN:
  - Each cycle the cell adds a_sr[0], b_sr[0] and carry.
  - The sum bit shifts into the MSB of the result register; a_sr and b_sr shift right.
  - The carry register takes the cell's carry-out and the counter increments.
  - When the counter = WIDTH-1, go to DONE after that cycle's update.
- DONE:
  - out_valid = 1.
  - sum is the fully shifted result register; cout is the carry register.
  - On out_ready, go to IDLE.
- in_ready is high only in IDLE. in_valid is ignored in RUN and DONE, and a, b, cin are don't-care when not accepted.
- sum and cout stay stable while out_valid = 1 and out_ready = 0.
- Arithmetic is unsigned and modulo 2^WIDTH; overflow is reported only through cout.
- Counter width is max(1, $clog2(WIDTH)). WIDTH = 1 goes IDLE → RUN (one cycle) → DONE.
- Reset in any state:
  - Next state is IDLE and any operation in flight is aborted without producing output.
  - Counter, carry, shift and result registers clear to 0.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, sum = 0, cout = 0.
- Latency: if operands are accepted on edge E, out_valid rises after edge E + WIDTH and is visible WIDTH cycles after acceptance.
- Minimum initiation interval is WIDTH + 2 cycles:
  - 1 accept cycle, WIDTH RUN cycles, at least 1 DONE cycle.
  - A new accept cannot occur in the same cycle as output acceptance.
- Back-pressure: DONE lasts until out_ready is seen high. There is no timeout.
- in_ready, out_valid, sum and cout are driven only from registers or state. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package serial_adder_pkg holds the state enum (IDLE, RUN, DONE).
- Sub-module fa_bit_cell is instantiated once: inputs a, b, cin; outputs s, cout; purely combinational.
- The top level holds the FSM, bit counter, carry register, and the a, b and result shift registers.

## Test plan
All scenarios use WIDTH = 8.
- Basic add: a = 0x12, b = 0x34, cin = 0 → sum = 0x46, cout = 0; out_valid 8 cycles after the accept edge.
- Full carry ripple: a = 0xFF, b = 0x01, cin = 0 → sum = 0x00, cout = 1. Also a = 0xA5, b = 0x5A, cin = 1 → sum = 0x00, cout = 1.
- Back-pressure: a = 0x80, b = 0x80, with out_ready held low for 5 cycles after out_valid → sum = 0x00 and cout = 1 held stable; in_ready stays 0; IDLE the cycle after out_ready = 1.
- Ignored input: in_valid pulsed with a = 0xFF during RUN of a = 0x01, b = 0x01 → result = 0x02, cout = 0; the second operand is never accepted.
- Reset mid-operation: rst for 1 cycle at RUN bit 3 → out_valid never asserts for that operation; in_ready = 1 the cycle after reset; a following a = 0x03, b = 0x04 returns 0x07.
- Back-to-back: two operations with out_ready tied high → accepts spaced exactly 10 cycles apart (WIDTH + 2), both results correct.
